serial_adder: RTL

- Bit-serial add/subtract engine built around one full_adder cell and a registered carry.
- Accepts two WIDTH-bit operands through a valid/ready input handshake.
- Adds them LSB-first, one bit per clock, and returns the WIDTH-bit result plus carry-out through a valid/ready output handshake.
- Serves as the area-minimal alternative to the ripple/parallel adders in the arithmetic datapath, for slow or control paths.

---
 rtl/arith_pkg.sv | 18 +
 rtl/full_adder.sv | 18 +
 rtl/serial_adder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// arith_pkg: shared definitions for the arithmetic datapath blocks.
//   - serial_add_state_e : control states of the bit-serial adder
//   - cnt_width()        : width of a bit counter that indexes 0..w-1,
//                          never narrower than one bit
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } serial_add_state_e;

    // $clog2(1) is 0, which would give a zero-width counter for WIDTH=1.
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell.
// Ports:
//   a, b  in  1  addend bits
//   ci    in  1  carry in
//   s     out 1  sum bit
//   co    out 1  carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract engine. Operands are accepted
// through a valid/ready handshake, added LSB-first one bit per clock
// through a single full_adder, and the result is held in DONE until the
// consumer takes it.
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operand set valid
//   in_ready   out  1      block idle, can accept operands
//   a, b       in   WIDTH  operands
//   cin        in   1      carry in for add (ignored for sub)
//   sub        in   1      0: a+b+cin, 1: a-b
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result
//   cout       out  1      carry out; for sub, 1 means no borrow
//   busy       out  1      operation in flight (SHIFT or DONE)
module serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    serial_add_state_e state, next_state;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH:0]   sum_cat;
    logic [CNT_W-1:0] cnt;
    logic             carry_q;
    logic             cout_q;
    logic             fa_s;
    logic             fa_co;

    full_adder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB; after WIDTH shifts the first bit
    // computed (the LSB) has reached bit 0. Built through a WIDTH+1 wide
    // concatenation so WIDTH=1 needs no special case.
    assign sum_cat = {fa_s, sum_sr};

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next state and handshake decode
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == LAST) next_state = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand capture and bit-serial datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction as a + ~b + 1.
                        a_sr    <= a;
                        b_sr    <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    sum_sr  <= sum_cat[WIDTH:1];
                    carry_q <= fa_co;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST) cout_q <= fa_co;
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_sr;
    assign cout = cout_q;

endmodule
